// File: rtl/data_bus_if_pkg.sv
// Shared types and constants for the 6502-style external data bus interface.
// Holds the bus-cycle FSM state enum, bus width and open-bus fill value.
package data_bus_if_pkg;

  localparam int DW = 8;

  localparam logic [DW-1:0] OPEN_BUS_FILL = 8'hFF;

  typedef enum logic [1:0] {
    ST_READ  = 2'd0,
    ST_WRITE = 2'd1,
    ST_STALL = 2'd2
  } state_t;

endpackage

// File: rtl/data_bus_if_latch.sv
// dbus_latch: W-bit register with load enable and async reset value.
// Ports: clk_i, rst_i (async, high), en_i load enable, d_i data, q_o value.
module dbus_latch #(
  parameter int          W       = 8,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= RST_VAL;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/data_bus_if.sv
// data_bus_if: 6502 data bus front end. PHI0 makes PHI1/PHI2; DL captures
// DB_in on reads, DOR drives DB_out on writes; RDY=0 repeats reads (STALL).
// Inputs: PHI0, RES, RnW, RDY, DB_in, DB_in_valid, DB_int, DL_DB/ADL/ADH.
// Outputs: PHI1, PHI2, DB_out, DB_oe, DL_q, DL_to_DB/ADL/ADH, STALL.
// Build option: DBUS_OPEN_BUS_EN keeps DL on undriven reads (else 8'hFF).
module data_bus_if
  import data_bus_if_pkg::*;
#(
  parameter logic [DW-1:0] DL_RESET = 8'hFF
) (
  input  logic          PHI0,
  input  logic          RES,
  output logic          PHI1,
  output logic          PHI2,
  input  logic          RnW,
  input  logic          RDY,
  input  logic [DW-1:0] DB_in,
  input  logic          DB_in_valid,
  output logic [DW-1:0] DB_out,
  output logic          DB_oe,
  input  logic [DW-1:0] DB_int,
  input  logic          DL_DB,
  input  logic          DL_ADL,
  input  logic          DL_ADH,
  output logic [DW-1:0] DL_q,
  output logic          DL_to_DB,
  output logic          DL_to_ADL,
  output logic          DL_to_ADH,
  output logic          STALL
);

  logic          ph_q;
  logic          ph_d;
  state_t        state_q;
  logic [DW-1:0] dl_q;
  logic [DW-1:0] dl_d;
  logic [DW-1:0] dor_q;
  logic          dl_en;
  logic          dor_en;

  assign ph_d = ~ph_q;

  always_ff @(posedge PHI0 or posedge RES) begin
    if (RES) begin
      ph_q <= 1'b0;
    end else begin
      ph_q <= ph_d;
    end
  end

  // ph_q=1 means this edge ends PHI2: the cycle is resolved here.
  always_ff @(posedge PHI0 or posedge RES) begin
    if (RES) begin
      state_q <= ST_READ;
    end else if (ph_q) begin
      unique case (1'b1)
        !RnW:       state_q <= ST_WRITE;
        RnW && RDY: state_q <= ST_READ;
        default:    state_q <= ST_STALL;
      endcase
    end
  end

`ifdef DBUS_OPEN_BUS_EN
  assign dl_d = DB_in_valid ? DB_in : dl_q;
`else
  assign dl_d = DB_in_valid ? DB_in : OPEN_BUS_FILL;
`endif

  assign dl_en  = ph_q & RnW & RDY;
  assign dor_en = ~ph_q & ~RnW;

  dbus_latch #(.W(DW), .RST_VAL(DL_RESET)) u_dl (
    .clk_i (PHI0),
    .rst_i (RES),
    .en_i  (dl_en),
    .d_i   (dl_d),
    .q_o   (dl_q)
  );

  dbus_latch #(.W(DW), .RST_VAL(DL_RESET)) u_dor (
    .clk_i (PHI0),
    .rst_i (RES),
    .en_i  (dor_en),
    .d_i   (DB_int),
    .q_o   (dor_q)
  );

  assign PHI1      = ~ph_q;
  assign PHI2      = ph_q;
  // ph_q clears asynchronously on RES, so a write aborts at once.
  assign DB_oe     = ph_q & ~RnW;
  assign DB_out    = dor_q;
  assign DL_q      = dl_q;
  assign DL_to_DB  = ~ph_q & DL_DB;
  assign DL_to_ADL = ~ph_q & DL_ADL;
  assign DL_to_ADH = ~ph_q & DL_ADH;
  assign STALL     = (state_q == ST_STALL);

endmodule

// File: tb/tb_data_bus_if.sv
// Directed bench for data_bus_if with an expected-DL scoreboard queue.
// Covers reset, read, write, stall, RnW change in PHI2, open bus, reset abort.
module tb_data_bus_if;

  logic       PHI0 = 1'b0;
  logic       RES;
  logic       PHI1, PHI2;
  logic       RnW, RDY;
  logic [7:0] DB_in;
  logic       DB_in_valid;
  logic [7:0] DB_out;
  logic       DB_oe;
  logic [7:0] DB_int;
  logic       DL_DB, DL_ADL, DL_ADH;
  logic [7:0] DL_q;
  logic       DL_to_DB, DL_to_ADL, DL_to_ADH;
  logic       STALL;

  int checks = 0;
  int fails  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] dl_m;
  logic [7:0] dor_m;

  data_bus_if dut (
    .PHI0        (PHI0),
    .RES         (RES),
    .PHI1        (PHI1),
    .PHI2        (PHI2),
    .RnW         (RnW),
    .RDY         (RDY),
    .DB_in       (DB_in),
    .DB_in_valid (DB_in_valid),
    .DB_out      (DB_out),
    .DB_oe       (DB_oe),
    .DB_int      (DB_int),
    .DL_DB       (DL_DB),
    .DL_ADL      (DL_ADL),
    .DL_ADH      (DL_ADH),
    .DL_q        (DL_q),
    .DL_to_DB    (DL_to_DB),
    .DL_to_ADL   (DL_to_ADL),
    .DL_to_ADH   (DL_to_ADH),
    .STALL       (STALL)
  );

  always #5 PHI0 = ~PHI0;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PHI0);
    #1;
  endtask

  task automatic pop_dl(input string tag);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 8'h00, 8'h01);
    end else begin
      chk(tag, DL_q, exp_q.pop_front());
    end
  endtask

  // Entered #1 into PHI1; leaves #1 into the next PHI1.
  task automatic run_cycle(input logic rnw, input logic rdy,
                           input logic [7:0] din, input logic vld,
                           input logic [7:0] dbint);
    RnW = rnw; RDY = rdy; DB_in = din;
    DB_in_valid = vld; DB_int = dbint;
    if (!rnw) dor_m = dbint;
    if (rnw && rdy) begin
`ifdef DBUS_OPEN_BUS_EN
      dl_m = vld ? din : dl_m;
`else
      dl_m = vld ? din : 8'hFF;
`endif
    end
    exp_q.push_back(dl_m);
    tick();
    chk("phi2", PHI2, 1'b1);
    chk("oe_ph2", DB_oe, !rnw);
    chk("dout", DB_out, dor_m);
    chk("dl2db_ph2", DL_to_DB, 1'b0);
    tick();
    chk("phi1", PHI1, 1'b1);
    chk("stall", STALL, rnw && !rdy);
    chk("oe_ph1", DB_oe, 1'b0);
    chk("dl2db_ph1", DL_to_DB, DL_DB);
    pop_dl("dl");
  endtask

  initial begin
    RES = 1'b1; RnW = 1'b1; RDY = 1'b1;
    DB_in = 8'hFF; DB_in_valid = 1'b1; DB_int = 8'h00;
    DL_DB = 1'b0; DL_ADL = 1'b0; DL_ADH = 1'b0;
    dl_m = 8'hFF; dor_m = 8'hFF;
    #23;
    chk("rst_phi1", PHI1, 1'b1);
    chk("rst_phi2", PHI2, 1'b0);
    chk("rst_dl", DL_q, 8'hFF);
    chk("rst_dout", DB_out, 8'hFF);
    chk("rst_oe", DB_oe, 1'b0);
    chk("rst_stall", STALL, 1'b0);
    @(negedge PHI0);
    RES = 1'b0;
    tick();
    chk("rel_phi2", PHI2, 1'b1);
    tick();
    chk("rel_dl", DL_q, 8'hFF);

    run_cycle(1'b1, 1'b1, 8'hA9, 1'b1, 8'h00);
    DL_DB = 1'b1;
    #1;
    chk("dl2db", DL_to_DB, 1'b1);
    chk("dl2adl_off", DL_to_ADL, 1'b0);
    DL_ADL = 1'b1; DL_ADH = 1'b1;
    #1;
    chk("dl2adl", DL_to_ADL, 1'b1);
    chk("dl2adh", DL_to_ADH, 1'b1);
    DL_ADL = 1'b0; DL_ADH = 1'b0;

    run_cycle(1'b0, 1'b1, 8'h00, 1'b1, 8'h5C);

    run_cycle(1'b1, 1'b0, 8'h11, 1'b1, 8'h00);
    run_cycle(1'b1, 1'b0, 8'h22, 1'b1, 8'h00);
    run_cycle(1'b1, 1'b0, 8'h33, 1'b1, 8'h00);
    run_cycle(1'b1, 1'b1, 8'h42, 1'b1, 8'h00);

    run_cycle(1'b0, 1'b0, 8'h00, 1'b1, 8'hC3);

    run_cycle(1'b1, 1'b1, 8'h12, 1'b1, 8'h00);
    run_cycle(1'b1, 1'b1, 8'h77, 1'b0, 8'h00);

    RnW = 1'b0; DB_int = 8'h99; DB_in = 8'h5A;
    DB_in_valid = 1'b1; RDY = 1'b1;
    dor_m = 8'h99; dl_m = 8'h5A;
    exp_q.push_back(dl_m);
    tick();
    chk("chg_oe_w", DB_oe, 1'b1);
    chk("chg_dout", DB_out, 8'h99);
    RnW = 1'b1;
    #1;
    chk("chg_oe_r", DB_oe, 1'b0);
    tick();
    pop_dl("chg_dl");
    chk("chg_stall", STALL, 1'b0);

    RnW = 1'b0; DB_int = 8'h3E;
    tick();
    chk("abt_oe_w", DB_oe, 1'b1);
    chk("abt_dout", DB_out, 8'h3E);
    #2;
    RES = 1'b1;
    #1;
    chk("abt_oe", DB_oe, 1'b0);
    chk("abt_phi1", PHI1, 1'b1);
    chk("abt_dl", DL_q, 8'hFF);
    chk("abt_dout_rst", DB_out, 8'hFF);
    RnW = 1'b1; DB_in = 8'hFF;
    @(negedge PHI0);
    RES = 1'b0;
    tick();
    chk("abt_rel_phi2", PHI2, 1'b1);
    chk("abt_rel_stall", STALL, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/data_bus_if.md
DATA_BUS_IF -- requirements
Module: data_bus_if

Interface
REQ-001 SHALL have parameter DL_RESET, default 8'hFF: reset value of the data latch (DL) and the data output register (DOR).
REQ-002 SHALL have port PHI0  input  1  single clock; rising edges only; two edges per 6502 cycle.
REQ-003 SHALL have port RES  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have ports PHI1, PHI2  output  1 each  internal half-clocks derived from PHI0.
REQ-005 SHALL have port RnW  input  1  cycle type from core; 1 = read, 0 = write.
REQ-006 SHALL have port RDY  input  1  ready; 0 stalls read cycles.
REQ-007 SHALL have ports DB_in  input  8  and DB_in_valid  input  1  external data terminals and their driven flag.
REQ-008 SHALL have ports DB_out  output  8  and DB_oe  output  1  external data terminals and their output enable.
REQ-009 SHALL have port DB_int  input  8  internal DB bus value, source for DOR.
REQ-010 SHALL have ports DL_DB, DL_ADL, DL_ADH  input  1 each  commands that place DL on internal buses.
REQ-011 SHALL have ports DL_q  output  8;  DL_to_DB, DL_to_ADL, DL_to_ADH  output  1 each  internal-bus drive enables.
REQ-012 SHALL have port STALL  output  1  high while the current read cycle is being repeated.

Function
REQ-013 SHALL hold a phase bit ph, toggled on every PHI0 edge; PHI1 = ~ph, PHI2 = ph.
REQ-014 SHALL implement FSM {READ, WRITE, STALL}, evaluated on the PHI0 edge that ends PHI2.
REQ-015 Next state SHALL be: RnW=0 -> WRITE; RnW=1 and RDY=1 -> READ; RnW=1 and RDY=0 -> STALL. RDY SHALL NOT affect writes.
REQ-016 On the edge ending PHI2: in READ/STALL evaluation with RnW=1 and RDY=1, DL SHALL load DB_in. With RDY=0, DL SHALL hold.
REQ-017 On the edge ending PHI1, DOR SHALL load DB_int when RnW=0; otherwise DOR SHALL hold.
REQ-018 DB_oe SHALL be 1 only during PHI2 of a cycle with RnW=0; DB_out SHALL equal DOR at all times.
REQ-019 DL_to_DB, DL_to_ADL, DL_to_ADH SHALL equal PHI1 AND DL_DB, DL_ADL, DL_ADH respectively; DL_q SHALL equal DL. Any combination of the three may be active at once.
REQ-020 STALL SHALL be 1 exactly while the FSM is in STALL. The DL value at stall exit SHALL be the DB_in sampled on the first PHI2 end with RDY=1.
REQ-021 If RnW changes during PHI2, the value sampled at the PHI2-ending edge SHALL decide the DL update. DB_oe SHALL follow RnW combinationally within PHI2.

Reset
REQ-022 While RES=1: ph=0 (PHI1 active), FSM=READ, DL=DOR=DL_RESET, DB_oe=0, STALL=0.
REQ-023 Reset asserted mid-cycle SHALL abort any write immediately (DB_oe=0 asynchronously). The first edge after release SHALL begin PHI2.

Configuration
REQ-024 Macro DBUS_OPEN_BUS_EN: when defined, a read with DB_in_valid=0 SHALL leave DL unchanged (open-bus retention). When undefined, DL SHALL load 8'hFF (pull-up behaviour). DB_in_valid=1 SHALL behave identically in both builds.

Structure
REQ-025 A shared package SHALL hold the FSM state enum {READ, WRITE, STALL}, the bus width constant 8 and the open-bus fill constant 8'hFF.
REQ-026 One sub-module, dbus_latch (8-bit register with load enable and asynchronous reset value), SHALL be instantiated twice, for DL and DOR.

Verification
REQ-027 RES pulse -> PHI1=1, DL_q=8'hFF, DB_oe=0, STALL=0; first PHI0 edge after release -> PHI2=1.
REQ-028 Read cycle: RnW=1, RDY=1, DB_in=8'h A9 valid -> DL_q=8'hA9 after PHI2 end. Next PHI1 with DL_DB=1 -> DL_to_DB=1.
REQ-029 Write cycle: RnW=0, DB_int=8'h5C in PHI1 -> PHI2: DB_oe=1, DB_out=8'h5C. Next PHI1: DB_oe=0.
REQ-030 Stall: RnW=1, RDY=0 for 3 cycles, DB_in changing -> STALL=1 for 3 cycles, DL unchanged. RDY=1 with DB_in=8'h42 -> DL_q=8'h42, STALL=0.
REQ-031 Write with RDY=0 -> DB_oe still 1 in PHI2, STALL=0.
REQ-032 Read with DB_in_valid=0 after DL=8'h12 -> DL_q=8'h12 with DBUS_OPEN_BUS_EN, 8'hFF without it.
